// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus conditioner.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Pin-side and local-logic-side signals of the I2C target.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addressed;
  logic       rw;
  logic       stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addressed, rw, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addressed, rw, stop_det
  );
endinterface

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchronizers plus registered edge and START/STOP detection.
// sda_o is aligned with the registered event flags.
module i2c_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_s, sda_s;
  logic scl_p_q, sda_p_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  // Previous-cycle copies and registered bus events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
      scl_rise_q <= scl_s & ~scl_p_q;
      scl_fall_q <= ~scl_s & scl_p_q;
      start_q    <= scl_s & scl_p_q & sda_p_q & ~sda_s;
      stop_q     <= scl_s & scl_p_q & ~sda_p_q & sda_s;
    end
  end

  assign sda_o      = sda_p_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit address I2C target: ACKs writes, serves reads, open-drain SDA only.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR        = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  i2c_target_if.slave bus
);

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_ev),
    .stop_o     (stop_ev)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_sh_q, tx_sh_d;
  logic       ack_pend_q, ack_pend_d;
  logic       rw_q, rw_d;
  logic       addressed_q, addressed_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       stop_det_q, stop_det_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_sh_q     <= '0;
      ack_pend_q  <= 1'b0;
      rw_q        <= 1'b0;
      addressed_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_sh_q     <= tx_sh_d;
      ack_pend_q  <= ack_pend_d;
      rw_q        <= rw_d;
      addressed_q <= addressed_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Next-state logic; bus START/STOP override any same-cycle SCL edge.
  // ack_pend bridges the 8th SCL rise to the following fall where ACK is driven;
  // tx_sh holds only bits 6..0 since bit 7 is driven straight from tx_data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_sh_d     = tx_sh_q;
    ack_pend_d  = ack_pend_q;
    rw_d        = rw_q;
    addressed_d = addressed_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    stop_det_d  = 1'b0;
    if (stop_ev) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      ack_pend_d  = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
    end else if (start_ev) begin
      state_d     = ST_ADDR;
      cnt_d       = '0;
      ack_pend_d  = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q == ADDR && ADDR != 7'd0) begin
                rw_d       = sda_s;
                ack_pend_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d  = 1'b0;
            sda_oe_d    = 1'b1;
            addressed_d = 1'b1;
            tx_req_d    = (rw_q == RW_READ);
            state_d     = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q == RW_READ) begin
              tx_sh_d  = bus.tx_data[6:0];
              sda_oe_d = ~bus.tx_data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q, sda_s};
              rx_valid_d = 1'b1;
              ack_pend_d = 1'b1;
            end
          end else if (scl_fall && ack_pend_q) begin
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b1;
            state_d    = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_TX_ACK;
            end else begin
              sda_oe_d = ~tx_sh_q[6];
              tx_sh_d  = {tx_sh_q[5:0], 1'b0};
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) tx_req_d = 1'b1;
            else              state_d  = ST_WAIT_STOP;
          end else if (scl_fall) begin
            tx_sh_d  = bus.tx_data[6:0];
            sda_oe_d = ~bus.tx_data[7];
            cnt_d    = '0;
            state_d  = ST_TX;
          end
        end
        ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.addressed = addressed_q;
  assign bus.rw        = rw_q;
  assign bus.stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-level bus driver with a transaction model.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] OWN = 7'h42;
  localparam int         Q   = 10;  // clk cycles per SCL half period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_target_if bus();

  i2c_target #(.ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Open-drain bus: initiator drives scl_m/sda_m, target can only pull SDA low.
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  int total = 0;
  int bad   = 0;

  // Model state
  logic       win = 1'b0;
  logic       exp_oe = 1'b0, exp_addr = 1'b0, exp_rw = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         n_rx = 0, n_txreq = 0, n_stop = 0, exp_n_stop = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: per-cycle checks in stable windows plus the rx scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_data = 8'h00;
    end else begin
      if (win) begin
        check("sda_oe", bus.sda_oe, exp_oe);
        check("addressed", bus.addressed, exp_addr);
        check("rw", bus.rw, exp_rw);
      end
      if (bus.rx_valid) begin
        n_rx++;
        if (rxq.size() == 0) check("rx_unexpected", 8'd1, 8'd0);
        else                 check("rx_data", bus.rx_data, rxq.pop_front());
      end
      if (bus.tx_req) begin
        n_txreq++;
        if (txq.size() == 0) check("tx_req_unexpected", 8'd1, 8'd0);
        else                 bus.tx_data = txq.pop_front();
      end
      if (bus.stop_det) n_stop++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sda_oe"}, bus.sda_oe, 8'd0);
    check({tag, "_rx_valid"}, bus.rx_valid, 8'd0);
    check({tag, "_tx_req"}, bus.tx_req, 8'd0);
    check({tag, "_addressed"}, bus.addressed, 8'd0);
    check({tag, "_rw"}, bus.rw, 8'd0);
    check({tag, "_stop_det"}, bus.stop_det, 8'd0);
    check({tag, "_rx_data"}, bus.rx_data, 8'h00);
  endtask

  // One SCL clock: initiator drives b (1 = release), target expected to drive eo.
  task automatic bit_xfer(input logic b, input logic eo, output logic rd);
    tick(1);
    sda_m = b;
    tick(Q - 1);
    scl_m = 1'b1;
    tick(5);
    exp_oe = eo;
    win = 1'b1;
    tick(3);
    rd = bus.sda_i;
    win = 1'b0;
    tick(2);
    scl_m = 1'b0;
  endtask

  task automatic do_start();
    if (scl_m) begin
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
    end else begin
      tick(Q / 2);
      sda_m = 1'b1;
      tick(Q / 2);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
    end
    exp_addr = 1'b0;
  endtask

  task automatic do_stop();
    tick(1);
    sda_m = 1'b0;
    tick(Q - 1);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
    exp_addr = 1'b0;
    exp_oe = 1'b0;
    exp_n_stop++;
    win = 1'b1;
    tick(3);
    win = 1'b0;
  endtask

  task automatic addr_bits(input logic [6:0] a, input logic rwb);
    logic r;
    exp_addr = 1'b0;
    for (int i = 6; i >= 0; i--) bit_xfer(a[i], 1'b0, r);
    if (a == OWN && a != 7'd0) exp_rw = rwb;
    bit_xfer(rwb, 1'b0, r);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rwb, output logic acked);
    logic r, hit;
    hit = (a == OWN) && (a != 7'd0);
    addr_bits(a, rwb);
    if (hit) exp_addr = 1'b1;
    bit_xfer(1'b1, hit, r);
    acked = ~r;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic ack_exp, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], 1'b0, r);
    bit_xfer(1'b1, ack_exp, r);
    acked = ~r;
  endtask

  task automatic rd_byte(input logic [7:0] exp_byte, input logic mack, output logic [7:0] got);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, ~exp_byte[i], r);
      got[i] = r;
    end
    bit_xfer(mack, 1'b0, r);
  endtask

  task automatic model_reset();
    exp_oe = 1'b0;
    exp_addr = 1'b0;
    exp_rw = 1'b0;
    rxq.delete();
    txq.delete();
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] got;

    tick(4);
    check_reset("rst0");
    rst_n = 1'b1;
    tick(10);

    // Write 0x42+W, 0xA5, 0x3C, STOP
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    check("t1_addr_ack", ack, 8'd1);
    rxq.push_back(8'hA5);
    wr_byte(8'hA5, 1'b1, ack);
    check("t1_d0_ack", ack, 8'd1);
    rxq.push_back(8'h3C);
    wr_byte(8'h3C, 1'b1, ack);
    check("t1_d1_ack", ack, 8'd1);
    do_stop();
    check("t1_rx_count", n_rx, 8'd2);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_stop_count", n_stop, 8'd1);

    // Foreign address 0x43, data 0x42: no ACK, nothing delivered
    do_start();
    addr_phase(7'h43, RW_WRITE, ack);
    check("t2_addr_nack", ack, 8'd0);
    wr_byte(8'h42, 1'b0, ack);
    check("t2_data_nack", ack, 8'd0);
    do_stop();
    check("t2_rx_count", n_rx, 8'd2);
    check("t2_txreq_count", n_txreq, 8'd0);

    // Read 0x96 (ACK) then 0x01 (NACK)
    txq.push_back(8'h96);
    txq.push_back(8'h01);
    do_start();
    addr_phase(OWN, RW_READ, ack);
    check("t3_addr_ack", ack, 8'd1);
    rd_byte(8'h96, ACK, got);
    check("t3_byte0", got, 8'h96);
    rd_byte(8'h01, NACK, got);
    check("t3_byte1", got, 8'h01);
    do_stop();
    check("t3_txreq_count", n_txreq, 8'd2);

    // Write 0x10, repeated START, read
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    check("t4_waddr_ack", ack, 8'd1);
    rxq.push_back(8'h10);
    wr_byte(8'h10, 1'b1, ack);
    check("t4_d0_ack", ack, 8'd1);
    check("t4_rw_before", bus.rw, 8'd0);
    txq.push_back(8'h5C);
    do_start();
    addr_phase(OWN, RW_READ, ack);
    check("t4_raddr_ack", ack, 8'd1);
    check("t4_rw_after", bus.rw, 8'd1);
    check("t4_rx_data", bus.rx_data, 8'h10);
    rd_byte(8'h5C, NACK, got);
    check("t4_rbyte", got, 8'h5C);
    do_stop();
    check("t4_txreq_count", n_txreq, 8'd3);

    // STOP after 4 data bits, then a normal write
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, r);
    do_stop();
    check("t5_rx_count", n_rx, 8'd3);
    check("t5_addressed", bus.addressed, 8'd0);
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    check("t5_addr_ack", ack, 8'd1);
    rxq.push_back(8'h77);
    wr_byte(8'h77, 1'b1, ack);
    do_stop();
    check("t5_rx_count2", n_rx, 8'd4);
    check("t5_rx_data", bus.rx_data, 8'h77);

    // Reset while the address ACK is driven
    do_start();
    addr_bits(OWN, RW_WRITE);
    exp_addr = 1'b1;
    tick(1);
    sda_m = 1'b1;
    tick(Q - 1);
    scl_m = 1'b1;
    tick(5);
    check("t6_ack_drive", bus.sda_oe, 8'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_release", bus.sda_oe, 8'd0);
    check_reset("t6_rst");
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(10);
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    check("t6_post_ack", ack, 8'd1);
    rxq.push_back(8'h5A);
    wr_byte(8'h5A, 1'b1, ack);
    do_stop();
    check("t6_rx_data", bus.rx_data, 8'h5A);

    // Reset mid-TX while a 0 bit is driven
    txq.push_back(8'h96);
    do_start();
    addr_bits(OWN, RW_READ);
    exp_addr = 1'b1;
    bit_xfer(1'b1, 1'b1, r);
    bit_xfer(1'b1, 1'b0, r);
    check("t6b_bit7", r, 8'd1);
    tick(1);
    sda_m = 1'b1;
    tick(Q - 1);
    scl_m = 1'b1;
    tick(5);
    check("t6b_tx0_drive", bus.sda_oe, 8'd1);
    rst_n = 1'b0;
    #1;
    check("t6b_async_release", bus.sda_oe, 8'd0);
    check_reset("t6b_rst");
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(10);
    do_start();
    addr_phase(OWN, RW_WRITE, ack);
    check("t6b_post_ack", ack, 8'd1);
    rxq.push_back(8'hC3);
    wr_byte(8'hC3, 1'b1, ack);
    do_stop();

    check("final_rx_count", n_rx, 8'd6);
    check("final_txreq_count", n_txreq, 8'd4);
    check("final_stop_count", n_stop, 8'd8);
    check("final_stop_model", n_stop, exp_n_stop[7:0]);
    check("final_rxq_drained", rxq.size(), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
